// File: rtl/fence_display_pkg.sv
// Shared display definitions: overlay colours, screen geometry, health types.
// Ports: none (package only).
// Zero colour is reserved for "transparent", so every palette entry is nonzero.
package fence_display_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int H_W      = 11;
  localparam int V_W      = 10;

  localparam logic [23:0] WHITE     = 24'hFFFFFF;
  localparam logic [23:0] GREEN     = 24'h00C000;
  localparam logic [23:0] RED       = 24'hE00000;
  localparam logic [23:0] YELLOW    = 24'hFFD000;
  localparam logic [23:0] DARK_GREY = 24'h303030;

  typedef logic [7:0] hp_t;

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    FLASH  = 2'd1,
    DRAIN  = 2'd2
  } health_state_t;

  function automatic hp_t clamp_hp(input hp_t hp, input hp_t max_hp);
    return (hp > max_hp) ? max_hp : hp;
  endfunction

endpackage

// File: rtl/health_drain_fsm.sv
// Damage animation state: hit flash, then per-frame drain of shown health toward target.
// Ports: clk_i/rst_i (async active-high), new_frame_i frame strobe, target_i clamped health;
//        shown_o displayed health, frame_tgt_o target latched per frame, flash_white_o, draining_o.
// All state advances only on new_frame_i, so the picture never changes mid-frame.
module health_drain_fsm
  import fence_display_pkg::*;
#(
  parameter int unsigned MAX_HP       = 100,
  parameter int unsigned DRAIN_STEP   = 1,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic new_frame_i,
  input  hp_t  target_i,
  output hp_t  shown_o,
  output hp_t  frame_tgt_o,
  output logic flash_white_o,
  output logic draining_o
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam hp_t MAX_HP_T = hp_t'(MAX_HP);
  localparam hp_t STEP     = hp_t'(DRAIN_STEP);

  health_state_t   state_q, state_d;
  hp_t             shown_q, shown_d;
  hp_t             ftgt_q, ftgt_d;
  logic [FC_W-1:0] flash_q, flash_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            draining_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= STEADY;
      shown_q    <= MAX_HP_T;
      ftgt_q     <= MAX_HP_T;
      flash_q    <= '0;
      fcnt_q     <= '0;
      draining_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shown_q    <= shown_d;
      ftgt_q     <= ftgt_d;
      flash_q    <= flash_d;
      fcnt_q     <= fcnt_d;
      draining_q <= (state_d != STEADY);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    ftgt_d  = ftgt_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (new_frame_i) begin
      fcnt_d = fcnt_q + 2'd1;
      // The fill edge is drawn from this per-frame copy so a mid-frame health change cannot tear the bar.
      ftgt_d = target_i;
      case (state_q)
        STEADY: begin
          if (target_i < shown_q) begin
            state_d = FLASH;
            flash_d = FLASH_LAST;
          end else begin
            shown_d = target_i;  // heals snap
          end
        end
        FLASH: begin
          if (target_i >= shown_q) begin
            shown_d = target_i;
            state_d = STEADY;
          end else if (flash_q == '0) begin
            state_d = DRAIN;
          end else begin
            flash_d = flash_q - FC_W'(1);
          end
        end
        DRAIN: begin
          if (target_i >= shown_q) begin
            shown_d = target_i;
            state_d = STEADY;
          end else if ((shown_q - target_i) <= STEP) begin
            // Saturate at target so shown never undershoots it.
            shown_d = target_i;
            state_d = STEADY;
          end else begin
            shown_d = shown_q - STEP;
          end
        end
        default: state_d = STEADY;
      endcase
    end
  end

  // Outputs
  always_comb begin
    shown_o       = shown_q;
    frame_tgt_o   = ftgt_q;
    flash_white_o = (state_q == FLASH) && fcnt_q[1];
    draining_o    = draining_q;
  end

endmodule

// File: rtl/health_bar_renderer.sv
// One fighter's health bar overlay: fill, ghost of recently lost health, empty track; 0 = transparent.
// Ports: clk_in/rst_in (async active-high), hcount_in/vcount_in scan position, new_frame_in, health_in;
//        pixel_out (1 cycle after hcount/vcount), draining_out (flash or drain in progress).
// Optional outline: define HEALTH_BAR_BORDER_EN for a 1-pixel WHITE box edge; latency is unchanged.
module health_bar_renderer
  import fence_display_pkg::*;
#(
  parameter int unsigned MAX_HP       = 100,
  parameter int unsigned PX_PER_HP    = 2,
  parameter int unsigned BAR_X        = 40,
  parameter int unsigned BAR_Y        = 20,
  parameter int unsigned BAR_H        = 12,
  parameter int unsigned MIRROR       = 0,
  parameter int unsigned DRAIN_STEP   = 1,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [H_W-1:0] hcount_in,
  input  logic [V_W-1:0] vcount_in,
  input  logic           new_frame_in,
  input  logic [7:0]     health_in,
  output logic [23:0]    pixel_out,
  output logic           draining_out
);

  localparam int unsigned BAR_LEN = MAX_HP * PX_PER_HP;
  localparam logic [15:0] X_LO   = 16'(BAR_X);
  localparam logic [15:0] X_HI   = 16'(BAR_X + BAR_LEN);
  localparam logic [15:0] X_LAST = 16'(BAR_X + BAR_LEN - 1);
  localparam logic [15:0] Y_LO   = 16'(BAR_Y);
  localparam logic [15:0] Y_HI   = 16'(BAR_Y + BAR_H);
  localparam logic [15:0] PPH    = 16'(PX_PER_HP);
  localparam hp_t MAX_HP_T = hp_t'(MAX_HP);
  localparam hp_t LOW_HP   = hp_t'(MAX_HP / 4);

  hp_t         target_q;
  hp_t         shown_hp;
  hp_t         frame_tgt;
  logic        flash_white;
  logic [23:0] pixel_q, pixel_d;

  logic [15:0] h_ext, v_ext, off, fill_len, ghost_len;
  logic        in_box;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      target_q <= MAX_HP_T;
      pixel_q  <= '0;
    end else begin
      target_q <= clamp_hp(health_in, MAX_HP_T);
      pixel_q  <= pixel_d;
    end
  end

  health_drain_fsm #(
    .MAX_HP      (MAX_HP),
    .DRAIN_STEP  (DRAIN_STEP),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_fsm (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .new_frame_i  (new_frame_in),
    .target_i     (target_q),
    .shown_o      (shown_hp),
    .frame_tgt_o  (frame_tgt),
    .flash_white_o(flash_white),
    .draining_o   (draining_out)
  );

  always_comb begin
    h_ext     = {{(16-H_W){1'b0}}, hcount_in};
    v_ext     = {{(16-V_W){1'b0}}, vcount_in};
    in_box    = (v_ext >= Y_LO) && (v_ext < Y_HI) && (h_ext >= X_LO) && (h_ext < X_HI);
    // Distance from the bar's "full" end; only meaningful inside the box.
    off       = (MIRROR != 0) ? (X_LAST - h_ext) : (h_ext - X_LO);
    fill_len  = {8'b0, frame_tgt} * PPH;
    ghost_len = {8'b0, shown_hp} * PPH;
  end

`ifdef HEALTH_BAR_BORDER_EN
  logic on_edge;
  always_comb begin
    on_edge = (v_ext == Y_LO) || (v_ext == Y_HI - 16'd1) || (h_ext == X_LO) || (h_ext == X_LAST);
  end
`endif

  always_comb begin
    pixel_d = '0;
    if (in_box) begin
      if (off < fill_len) begin
        if (flash_white)                pixel_d = WHITE;
        else if (frame_tgt <= LOW_HP)   pixel_d = RED;
        else                            pixel_d = GREEN;
      end else if (off < ghost_len) begin
        pixel_d = YELLOW;
      end else begin
        pixel_d = DARK_GREY;
      end
`ifdef HEALTH_BAR_BORDER_EN
      if (on_edge) pixel_d = WHITE;
`endif
    end
  end

  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_health_bar_renderer.sv
module tb_health_bar_renderer;
  import fence_display_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = 11'd100;
  logic [9:0]  vcount = 10'd21;
  logic        new_frame = 1'b0;
  logic [7:0]  health = 8'd100;
  logic [23:0] pixel, pixel_m;
  logic        drain, drain_m;

  int checks = 0;
  int failures = 0;

`ifdef HEALTH_BAR_BORDER_EN
  localparam logic [23:0] EDGE_FILL = WHITE;
`else
  localparam logic [23:0] EDGE_FILL = GREEN;
`endif

  always #5 clk = ~clk;

  health_bar_renderer dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .new_frame_in(new_frame), .health_in(health), .pixel_out(pixel), .draining_out(drain)
  );

  health_bar_renderer #(.MIRROR(1)) dut_m (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .new_frame_in(new_frame), .health_in(health), .pixel_out(pixel_m), .draining_out(drain_m)
  );

  // ---- stimulus helpers (no checking inside) ----
  task automatic sample(input logic [10:0] x, input logic [9:0] y, output logic [23:0] p, output logic [23:0] pm);
    @(negedge clk);
    hcount = x;
    vcount = y;
    @(posedge clk);
    #1;
    p  = pixel;
    pm = pixel_m;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    #1;
  endtask

  task automatic set_health(input logic [7:0] h);
    health = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    health = 8'd100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_steady(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      pulse_frame();
      if (!drain) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [23:0] p, pm;
    logic [10:0] xs [7] = '{11'd39, 11'd40, 11'd41, 11'd100, 11'd238, 11'd239, 11'd240};
    logic [23:0] ex [7] = '{24'h0, EDGE_FILL, GREEN, GREEN, GREEN, EDGE_FILL, 24'h0};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pixel !== 24'h0) begin failures++; $display("FAIL reset_pixel got=%h exp=%h", pixel, 24'h0); end
    checks++;
    if (drain !== 1'b0) begin failures++; $display("FAIL reset_draining got=%b exp=0", drain); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample(xs[i], 10'd21, p, pm);
      checks++;
      if (p !== ex[i]) begin failures++; $display("FAIL full_bar x=%0d got=%h exp=%h", xs[i], p, ex[i]); end
    end
    sample(11'd100, 10'd19, p, pm);
    checks++;
    if (p !== 24'h0) begin failures++; $display("FAIL above_box got=%h exp=0", p); end
    sample(11'd100, 10'd32, p, pm);
    checks++;
    if (p !== 24'h0) begin failures++; $display("FAIL below_box got=%h exp=0", p); end
    sample(11'd100, 10'd31, p, pm);
    checks++;
    if (p !== EDGE_FILL) begin failures++; $display("FAIL last_row got=%h exp=%h", p, EDGE_FILL); end
    // latency: pixel for x=41 appears only after the next rising edge
    sample(11'd39, 10'd21, p, pm);
    @(negedge clk);
    hcount = 11'd41;
    #1;
    checks++;
    if (pixel !== 24'h0) begin failures++; $display("FAIL latency_hold got=%h exp=0", pixel); end
    @(posedge clk);
    #1;
    checks++;
    if (pixel !== GREEN) begin failures++; $display("FAIL latency_edge got=%h exp=%h", pixel, GREEN); end
  endtask

  task automatic test_damage();
    logic [23:0] p, pm;
    do_reset();
    set_health(8'd70);
    sample(11'd190, 10'd21, p, pm);
    checks++;
    if (p !== GREEN || drain !== 1'b0) begin
      failures++; $display("FAIL midframe_hold got=%h/%b exp=%h/0", p, drain, GREEN);
    end
    pulse_frame();  // frame 1: FLASH, blink off
    sample(11'd190, 10'd21, p, pm);
    checks++;
    if (p !== YELLOW) begin failures++; $display("FAIL ghost_on_hit got=%h exp=%h", p, YELLOW); end
    sample(11'd100, 10'd21, p, pm);
    checks++;
    if (p !== GREEN || drain !== 1'b1) begin
      failures++; $display("FAIL flash_f1 got=%h/%b exp=%h/1", p, drain, GREEN);
    end
    pulse_frame();  // frame 2: blink on
    sample(11'd100, 10'd21, p, pm);
    checks++;
    if (p !== WHITE) begin failures++; $display("FAIL flash_white got=%h exp=%h", p, WHITE); end
    repeat (6) pulse_frame();  // frames 3..8 still FLASH
    checks++;
    if (drain !== 1'b1) begin failures++; $display("FAIL flash_f8 got=%b exp=1", drain); end
    pulse_frame();  // frame 9: DRAIN, shown still 100
    sample(11'd238, 10'd21, p, pm);
    checks++;
    if (p !== YELLOW || drain !== 1'b1) begin
      failures++; $display("FAIL drain_start got=%h/%b exp=%h/1", p, drain, YELLOW);
    end
    pulse_frame();  // frame 10: shown 99
    sample(11'd238, 10'd21, p, pm);
    checks++;
    if (p !== DARK_GREY) begin failures++; $display("FAIL drain_step got=%h exp=%h", p, DARK_GREY); end
    sample(11'd100, 10'd21, p, pm);
    checks++;
    if (p !== GREEN) begin failures++; $display("FAIL no_blink_in_drain got=%h exp=%h", p, GREEN); end
    repeat (28) pulse_frame();  // frame 38: shown 71
    sample(11'd180, 10'd21, p, pm);
    checks++;
    if (p !== YELLOW || drain !== 1'b1) begin
      failures++; $display("FAIL drain_f38 got=%h/%b exp=%h/1", p, drain, YELLOW);
    end
    pulse_frame();  // frame 39: shown 70, STEADY
    sample(11'd180, 10'd21, p, pm);
    checks++;
    if (p !== DARK_GREY || drain !== 1'b0) begin
      failures++; $display("FAIL drain_done got=%h/%b exp=%h/0", p, drain, DARK_GREY);
    end
    sample(11'd179, 10'd21, p, pm);
    checks++;
    if (p !== GREEN) begin failures++; $display("FAIL fill_edge_70 got=%h exp=%h", p, GREEN); end
  endtask

  task automatic test_heal_during_drain();
    logic [23:0] p, pm;
    do_reset();
    set_health(8'd70);
    repeat (24) pulse_frame();  // shown 85
    sample(11'd209, 10'd21, p, pm);
    checks++;
    if (p !== YELLOW || drain !== 1'b1) begin
      failures++; $display("FAIL shown85_ghost got=%h/%b exp=%h/1", p, drain, YELLOW);
    end
    sample(11'd210, 10'd21, p, pm);
    checks++;
    if (p !== DARK_GREY) begin failures++; $display("FAIL shown85_empty got=%h exp=%h", p, DARK_GREY); end
    set_health(8'd100);
    pulse_frame();
    sample(11'd210, 10'd21, p, pm);
    checks++;
    if (p !== GREEN || drain !== 1'b0) begin
      failures++; $display("FAIL heal_snap got=%h/%b exp=%h/0", p, drain, GREEN);
    end
  endtask

  task automatic test_low_and_clamp();
    logic [23:0] p, pm;
    bit ok;
    logic [10:0] xs [4] = '{11'd41, 11'd79, 11'd80, 11'd150};
    logic [23:0] ex [4] = '{RED, RED, DARK_GREY, DARK_GREY};
    do_reset();
    set_health(8'd20);
    run_until_steady(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL settle_20 got=timeout exp=steady"); end
    for (int i = 0; i < 4; i++) begin
      sample(xs[i], 10'd21, p, pm);
      checks++;
      if (p !== ex[i]) begin failures++; $display("FAIL hp20 x=%0d got=%h exp=%h", xs[i], p, ex[i]); end
    end
    set_health(8'd25);
    pulse_frame();
    sample(11'd89, 10'd21, p, pm);
    checks++;
    if (p !== RED) begin failures++; $display("FAIL hp25_red got=%h exp=%h", p, RED); end
    set_health(8'd26);
    pulse_frame();
    sample(11'd91, 10'd21, p, pm);
    checks++;
    if (p !== GREEN) begin failures++; $display("FAIL hp26_green got=%h exp=%h", p, GREEN); end
    set_health(8'd255);
    pulse_frame();
    sample(11'd238, 10'd21, p, pm);
    checks++;
    if (p !== GREEN || drain !== 1'b0) begin
      failures++; $display("FAIL clamp_255 got=%h/%b exp=%h/0", p, drain, GREEN);
    end
    sample(11'd240, 10'd21, p, pm);
    checks++;
    if (p !== 24'h0) begin failures++; $display("FAIL clamp_outside got=%h exp=0", p); end
    set_health(8'd0);
    pulse_frame();
    sample(11'd41, 10'd21, p, pm);
    checks++;
    if (p !== YELLOW || drain !== 1'b1) begin
      failures++; $display("FAIL hp0_ghost got=%h/%b exp=%h/1", p, drain, YELLOW);
    end
    run_until_steady(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL settle_0 got=timeout exp=steady"); end
    sample(11'd41, 10'd21, p, pm);
    checks++;
    if (p !== DARK_GREY) begin failures++; $display("FAIL hp0_empty got=%h exp=%h", p, DARK_GREY); end
  endtask

  task automatic test_mirror();
    logic [23:0] p, pm;
    bit ok;
    logic [10:0] xs [4] = '{11'd41, 11'd139, 11'd140, 11'd238};
    logic [23:0] en [4] = '{GREEN, GREEN, DARK_GREY, DARK_GREY};
    logic [23:0] em [4] = '{DARK_GREY, DARK_GREY, GREEN, GREEN};
    do_reset();
    set_health(8'd50);
    run_until_steady(200, ok);
    checks++;
    if (!ok || drain_m !== 1'b0) begin failures++; $display("FAIL settle_50 got=%b/%b exp=1/0", ok, drain_m); end
    for (int i = 0; i < 4; i++) begin
      sample(xs[i], 10'd21, p, pm);
      checks++;
      if (pm !== em[i]) begin failures++; $display("FAIL mirror x=%0d got=%h exp=%h", xs[i], pm, em[i]); end
      checks++;
      if (p !== en[i]) begin failures++; $display("FAIL normal50 x=%0d got=%h exp=%h", xs[i], p, en[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] p, pm;
    do_reset();
    set_health(8'd70);
    pulse_frame();
    sample(11'd100, 10'd21, p, pm);
    checks++;
    if (drain !== 1'b1) begin failures++; $display("FAIL pre_reset_flash got=%b exp=1", drain); end
    #2;
    rst = 1'b1;
    health = 8'd100;
    #1;
    checks++;
    if (pixel !== 24'h0 || drain !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%b exp=0/0", pixel, drain);
    end
    @(negedge clk);
    rst = 1'b0;
    sample(11'd100, 10'd21, p, pm);
    checks++;
    if (p !== GREEN || drain !== 1'b0) begin
      failures++; $display("FAIL post_reset_bar got=%h/%b exp=%h/0", p, drain, GREEN);
    end
    sample(11'd100, 10'd20, p, pm);
    checks++;
    if (p !== EDGE_FILL) begin failures++; $display("FAIL top_row got=%h exp=%h", p, EDGE_FILL); end
  endtask

  initial begin
    test_reset();
    test_damage();
    test_heal_during_drain();
    test_low_and_clamp();
    test_mirror();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
